// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS controller:
// FSM states, opcode/funct values, ALU control codes and mux select encodings.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ORIEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_FUNCT = 2'b10,
        AOP_OR    = 2'b11
    } aluop_t;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's ALU operation class plus funct to alucontrol,
// and flags funct values the datapath does not implement.
module mc_aludec
    import mips_pkg::*;
#(
    parameter int FUNCT_W = 6
) (
    input  aluop_t             aluop,
    input  logic [FUNCT_W-1:0] funct,
    output logic [2:0]         alucontrol,
    output logic               funct_illegal
);

    logic [2:0] funct_alu;

    always_comb begin
        funct_alu     = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct)
            F_ADD:   funct_alu = ALU_ADD;
            F_SUB:   funct_alu = ALU_SUB;
            F_AND:   funct_alu = ALU_AND;
            F_OR:    funct_alu = ALU_OR;
            F_SLT:   funct_alu = ALU_SLT;
            default: funct_illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (aluop)
            AOP_SUB:   alucontrol = ALU_SUB;
            AOP_FUNCT: alucontrol = funct_alu;
            AOP_OR:    alucontrol = ALU_OR;
            default:   alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore-style controller for a shared-memory multicycle MIPS datapath.
// op/funct are captured in DECODE so later states never depend on the live IR.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               pcen,
    output logic               regwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic               zeroext,
    output logic [1:0]         pcsrc,
    output logic [2:0]         alucontrol,
    output logic               illegal
);

    state_t             state_q, state_d;
    // variant_q distinguishes sw from lw in MEMADR and bne from beq in BRANCH
    logic               variant_q, variant_d;
    logic [FUNCT_W-1:0] funct_q, funct_d;
    logic [FUNCT_W-1:0] funct_sel;
    aluop_t             aluop;
    logic               funct_illegal;

    assign funct_sel = (state_q == S_DECODE) ? funct : funct_q;

    mc_aludec #(.FUNCT_W(FUNCT_W)) u_aludec (
        .aluop         (aluop),
        .funct         (funct_sel),
        .alucontrol    (alucontrol),
        .funct_illegal (funct_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            variant_q <= 1'b0;
            funct_q   <= '0;
        end else begin
            state_q   <= state_d;
            variant_q <= variant_d;
            funct_q   <= funct_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        variant_d = variant_q;
        funct_d   = funct_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                funct_d   = funct;
                variant_d = (op == OP_SW) || (op == OP_BNE);
                case (op)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_RTYPE:       state_d = funct_illegal ? S_FETCH : S_EXEC;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:        state_d = S_ADDIEX;
                    OP_ORI:         state_d = S_ORIEX;
                    OP_J:           state_d = S_JUMP;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = variant_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_IMMWB;
            S_ORIEX:  state_d = S_IMMWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        pcen     = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_RT;
        zeroext  = 1'b0;
        pcsrc    = PCSRC_ALU;
        aluop    = AOP_ADD;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = SRCB_FOUR;
                irwrite = mem_ready;
                pcen    = mem_ready;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
                case (op)
                    OP_RTYPE: illegal = funct_illegal;
                    OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J: illegal = 1'b0;
                    default:  illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = mem_ready;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = AOP_FUNCT;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = AOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                pcen    = variant_q ? ~zero : zero;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_ORIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                zeroext = 1'b1;
                aluop   = AOP_OR;
            end
            S_IMMWB:  regwrite = 1'b1;
            S_JUMP: begin
                pcsrc = PCSRC_JUMP;
                pcen  = 1'b1;
            end
            default: ;
        endcase
        // Strobes are suppressed for as long as reset is held, even in FETCH
        if (!reset) begin
            mem_req  = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            pcen     = 1'b0;
            regwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule
